// File: rtl/tff_counter_ctrl_if.sv
// Control and observation bundle for the T flip-flop bank sequencer.
// The master side requests runs; the slave side is the controller.
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;

    modport master (
        output start, pause, up, limit,
        input  q, qb, t_vec, busy, done
    );

    modport slave (
        input  start, pause, up, limit,
        output q, qb, t_vec, busy, done
    );
endinterface

// File: rtl/tff_counter_ctrl.sv
// Start/pause/done sequencer driving the toggle enables of a WIDTH-bit T-FF bank.
// The bank only ever changes through toggles, so loading is done by toggling q ^ load_val.
//
// state | meaning
// IDLE  | bank holds, waiting for start
// LOAD  | bank toggled to load_val
// COUNT | step toward end_val unless paused
// DONE  | one-cycle completion pulse
module tff_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    tff_counter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] lim_r;
    logic             dir_r;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] up_vec;
    logic [WIDTH-1:0] dn_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            dir_r <= 1'b1;
            lim_r <= '0;
        end else begin
            state <= state_nx;
            q     <= q ^ t_vec;
            if (state == IDLE && bus.start) begin
                dir_r <= bus.up;
                lim_r <= bus.limit;
            end
        end
    end

    assign load_val = dir_r ? '0 : lim_r;
    assign end_val  = dir_r ? lim_r : '0;

    // Ripple-style increment/decrement toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic acc_up;
        logic acc_dn;
        up_vec = '0;
        dn_vec = '0;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_vec[i] = acc_up;
            dn_vec[i] = acc_dn;
            acc_up    = acc_up & q[i];
            acc_dn    = acc_dn & ~q[i];
        end
    end

    always_comb begin
        state_nx = state;
        t_vec    = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = LOAD;
            end
            LOAD: begin
                t_vec    = q ^ load_val;
                state_nx = COUNT;
            end
            COUNT: begin
                if (bus.pause) begin
                    t_vec = '0;
                end else if (q == end_val) begin
                    state_nx = DONE;
                end else begin
                    t_vec = dir_r ? up_vec : dn_vec;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.q     = q;
    assign bus.qb    = ~q;
    assign bus.t_vec = t_vec;
    assign bus.busy  = (state == LOAD) || (state == COUNT);
    assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed bench for the T-FF bank sequencer: reset, up/down runs, pause, full range, abort.
module tb_tff_counter_ctrl;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tff_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

    tff_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.up    = 1'b1;
        bus.limit = '0;

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_qb", 32'(bus.qb), 32'hF);
        chk("rst_tvec", 32'(bus.t_vec), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        step();
        #2 rst = 1'b0;
        step();
        chk("idle_q", 32'(bus.q), 32'h0);

        // Up run, limit 5
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd5;
        step();
        bus.start = 1'b0; bus.up = 1'b0; bus.limit = 4'd2;
        chk("up5_load_busy", 32'(bus.busy), 32'h1);
        chk("up5_load_tvec", 32'(bus.t_vec), 32'h0);
        step();
        chk("up5_e1_q", 32'(bus.q), 32'h0);
        chk("up5_e1_tvec", 32'(bus.t_vec), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("up5_q", 32'(bus.q), 32'(k));
            chk("up5_nodone", 32'(bus.done), 32'h0);
        end
        chk("up5_end_tvec", 32'(bus.t_vec), 32'h0);
        chk("up5_end_busy", 32'(bus.busy), 32'h1);
        step();
        chk("up5_done", 32'(bus.done), 32'h1);
        chk("up5_done_busy", 32'(bus.busy), 32'h0);
        chk("up5_hold_q", 32'(bus.q), 32'h5);
        step();
        chk("up5_done_off", 32'(bus.done), 32'h0);

        // Down run, limit 9, from q = 5
        bus.start = 1'b1; bus.up = 1'b0; bus.limit = 4'd9;
        step();
        bus.start = 1'b0;
        chk("dn9_load_tvec", 32'(bus.t_vec), 32'hC);
        step();
        chk("dn9_e1_q", 32'(bus.q), 32'h9);
        for (int k = 1; k <= 9; k++) begin
            if (bus.q == 4'd8) chk("dn9_tvec_8", 32'(bus.t_vec), 32'hF);
            if (bus.q == 4'd6) chk("dn9_tvec_6", 32'(bus.t_vec), 32'h3);
            step();
            chk("dn9_q", 32'(bus.q), 32'(9 - k));
        end
        chk("dn9_nodone", 32'(bus.done), 32'h0);
        step();
        chk("dn9_done", 32'(bus.done), 32'h1);
        chk("dn9_hold_q", 32'(bus.q), 32'h0);
        step();
        chk("dn9_done_off", 32'(bus.done), 32'h0);

        // Up run, limit 3, paused two cycles at q = 1, stray start ignored
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd3;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("pz_q1", 32'(bus.q), 32'h1);
        bus.pause = 1'b1; bus.start = 1'b1;
        #0;
        chk("pz_tvec0", 32'(bus.t_vec), 32'h0);
        step();
        chk("pz_hold1", 32'(bus.q), 32'h1);
        chk("pz_tvec1", 32'(bus.t_vec), 32'h0);
        step();
        chk("pz_hold2", 32'(bus.q), 32'h1);
        bus.pause = 1'b0; bus.start = 1'b0;
        step();
        chk("pz_q2", 32'(bus.q), 32'h2);
        step();
        chk("pz_q3", 32'(bus.q), 32'h3);
        chk("pz_nodone", 32'(bus.done), 32'h0);
        step();
        chk("pz_done", 32'(bus.done), 32'h1);
        step();
        chk("pz_idle_busy", 32'(bus.busy), 32'h0);
        chk("pz_idle_q", 32'(bus.q), 32'h3);

        // Full range up run from q = 3
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd15;
        step();
        bus.start = 1'b0;
        chk("fr_load_tvec", 32'(bus.t_vec), 32'h3);
        step();
        chk("fr_e1_q", 32'(bus.q), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            if (bus.q == 4'd7) chk("fr_tvec_7", 32'(bus.t_vec), 32'hF);
            step();
            chk("fr_q", 32'(bus.q), 32'(k));
        end
        chk("fr_end_tvec", 32'(bus.t_vec), 32'h0);
        step();
        chk("fr_done", 32'(bus.done), 32'h1);
        chk("fr_nowrap", 32'(bus.q), 32'hF);
        step();

        // Zero-length up run from q = 15
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd0;
        step();
        bus.start = 1'b0;
        chk("z_load_tvec", 32'(bus.t_vec), 32'hF);
        step();
        chk("z_e1_q", 32'(bus.q), 32'h0);
        chk("z_e1_nodone", 32'(bus.done), 32'h0);
        step();
        chk("z_done", 32'(bus.done), 32'h1);
        step();
        chk("z_done_off", 32'(bus.done), 32'h0);

        // Abort at q = 6, then a fresh run
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd9;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("ab_q6", 32'(bus.q), 32'h6);
        #2 rst = 1'b1;
        #1;
        chk("ab_q", 32'(bus.q), 32'h0);
        chk("ab_busy", 32'(bus.busy), 32'h0);
        chk("ab_done", 32'(bus.done), 32'h0);
        chk("ab_tvec", 32'(bus.t_vec), 32'h0);
        step();
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ab_idle_done", 32'(bus.done), 32'h0);
            chk("ab_idle_q", 32'(bus.q), 32'h0);
        end
        bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd2;
        step();
        bus.start = 1'b0;
        chk("rr_busy", 32'(bus.busy), 32'h1);
        step();
        chk("rr_e1_q", 32'(bus.q), 32'h0);
        step();
        chk("rr_e2_q", 32'(bus.q), 32'h1);
        step();
        chk("rr_e3_q", 32'(bus.q), 32'h2);
        step();
        chk("rr_done", 32'(bus.done), 32'h1);
        step();
        chk("rr_done_off", 32'(bus.done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
